traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

Four-approach traffic signal sequencer that sits directly downstream of the image-matching classifier (`TrafficSystem`). It consumes classified vehicle results (class 1..26 plus the camera lane that produced the frame) and drives the four light boards. By default it rotates green round-robin across lanes 0..3 with fixed green/yellow/all-red intervals. Emergency-class detections preempt the rotation and grant green to the requesting lane.

## Interface
Parameters:
- `GREEN_CYC`, default 16: normal green duration, in cycles.
- `YELLOW_CYC`, default 4: yellow duration, in cycles.
- `ALLRED_CYC`, default 2: all-red clearance duration, in cycles.
- `EMERG_CYC`, default 24: preempted (emergency) green duration, in cycles.
- `EMERG_LO`, default 25: lowest class value treated as emergency.
- `EMERG_HI`, default 26: highest class value treated as emergency.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `cls_valid`, in, 1: classifier result valid.
- `cls_data`, in, 6: class value; 1..26 are legal, 0 and 27..63 are illegal.
- `cls_lane`, in, 2: lane whose camera produced the frame.
- `cls_ready`, out, 1: the block can accept a result.
- `lights`, out, 8: four 2-bit light codes; lane n occupies bits [2n+1:2n]. Codes: RED=0, YELLOW=1, GREEN=2 (3 is never driven).
- `phase_lane`, out, 2: lane currently green, yellow, or last served.
- `preempt_active`, out, 1: high while in emergency green.
- `drop_cnt`, out, 8: saturating count of emergency results lost because a request was already pending.

## Operation
- **Handshake:** a transfer occurs when `cls_valid && cls_ready`. `cls_ready` = !`pend_valid`, except that it is held high while `pend_valid` so that results are still consumed (see the drop rule below).
- **Emergency capture:** an accepted result with `EMERG_LO` ≤ `cls_data` ≤ `EMERG_HI` and `pend_valid`=0 sets `pend_valid`=1 and `pend_lane`=`cls_lane`.
- **Emergency drop:** an emergency result that arrives while `pend_valid`=1 is dropped and `drop_cnt` increments, saturating at 255.
- **Non-emergency results:** legal classes below `EMERG_LO` and illegal classes are consumed and ignored.
- **State machine:** states are GREEN, YELLOW, ALLRED and EGREEN. `cur_lane` is the lane being served.
  - **GREEN:** `lights[cur_lane]`=GREEN, all other lanes RED.
    - Timer expiry → YELLOW.
    - `pend_valid` with `pend_lane`≠`cur_lane` → YELLOW on the next cycle (early cut).
    - `pend_valid` with `pend_lane`==`cur_lane` → EGREEN and clear `pend_valid` (the green is extended).
  - **YELLOW:** `cur_lane` shows YELLOW. On expiry → ALLRED, and latch `next_lane` = `pend_valid` ? `pend_lane` : `cur_lane`+1 (mod 4).
  - **ALLRED:** all lanes RED. On expiry:
    - if `pend_valid` and `pend_lane`==`next_lane` → EGREEN on `next_lane` and clear `pend_valid`;
    - otherwise → GREEN on `next_lane`.
  - **EGREEN:** `cur_lane` shows GREEN and `preempt_active`=1. A request captured during EGREEN stays pending and is not acted on. On expiry → YELLOW. The normal rotation then resumes at `cur_lane`+1, unless a request is pending.
- Each state's timer is loaded with (duration − 1) on entry and moves on when it reaches 0. A state therefore lasts exactly its parameter's number of cycles. An early cut overrides the timer.
- A lane never goes GREEN→RED directly; YELLOW and ALLRED always intervene, including on an early cut.

## Timing
- **Reset values:** state=ALLRED, timer=`ALLRED_CYC`−1, `cur_lane`=`next_lane`=0, `lights`=8'h00, `phase_lane`=0, `preempt_active`=0, `pend_valid`=0, `drop_cnt`=0, `cls_ready`=1.
- All outputs are registered, so a state change is visible on the outputs at the edge where the state register updates.
- **Latency:** a result accepted at edge k sets `pend_valid` at edge k. From GREEN on another lane, YELLOW appears at edge k+1.
- **Simultaneous events:** if the timer expires in the same cycle as a new emergency acceptance, the transition uses the old `pend_valid` value. The new request is then served at the next decision point.
- **Reset mid-operation:** reset forces the reset values immediately, regardless of the clock. Any pending request is lost.

## Structure
- **Package `traffic_pkg`:** light codes (RED/YELLOW/GREEN), the state enum, class limits (`CLASS_MIN`=1, `CLASS_MAX`=26) and the lane count (4).
- **Sub-module `phase_timer`:** 8-bit down-counter with `load`, `load_val` and `done` (high when count==0). It is instantiated once.
- Everything else (FSM, request register, drop counter, light decode) lives in `traffic_phase_ctrl`.

## Test plan
- **Reset and free rotation:** release reset with no input → RED ×2, lane0 GREEN ×16, YELLOW ×4, RED ×2, then lane1 GREEN. After lane3, lane0 is served again.
- **Early cut:** send class 25 for lane 2 at the 5th cycle of lane0 GREEN → lane0 YELLOW on the next cycle. Sequence continues ALLRED ×2, then lane2 GREEN with `preempt_active`=1 for 24 cycles, then YELLOW, ALLRED, then lane3 GREEN.
- **Same-lane extension:** send class 26 for lane 1 during lane1 GREEN → EGREEN on the next cycle for 24 cycles, with no yellow gap before it.
- **Drop counting:** send three class-25 results back-to-back while a request is pending → `drop_cnt`=3 and the original `pend_lane` is unchanged. Send 300 drops → `drop_cnt`=255.
- **Ignored classes:** send classes 0, 12 and 63 → rotation timing is unchanged, `pend_valid` stays 0 and `drop_cnt` stays 0.
- **Reset mid-operation:** assert `rst_n` during EGREEN → `lights`=0 and `preempt_active`=0 immediately. After release, rotation restarts with lane0 after 2 all-red cycles.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the four-approach traffic phase controller:
// light codes, controller states, class limits and lane count.
package traffic_pkg;

    typedef enum logic [1:0] {
        LIGHT_RED    = 2'd0,
        LIGHT_YELLOW = 2'd1,
        LIGHT_GREEN  = 2'd2
    } light_t;

    typedef enum logic [1:0] {
        ST_GREEN,
        ST_YELLOW,
        ST_ALLRED,
        ST_EGREEN
    } state_t;

    localparam int unsigned CLASS_MIN = 1;
    localparam int unsigned CLASS_MAX = 26;
    localparam int unsigned NUM_LANES = 4;

    function automatic logic in_range(input logic [5:0] v, input int unsigned lo,
                                      input int unsigned hi);
        return (32'(v) >= lo) && (32'(v) <= hi);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// 8-bit down-counter for phase durations; done is high while the count is zero.
module phase_timer #(
    parameter logic [7:0] RST_VAL = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 8'd1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Round-robin four-lane signal sequencer with emergency preemption driven by
// classifier results; all light/status outputs are registered.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_CYC  = 16,
    parameter int unsigned YELLOW_CYC = 4,
    parameter int unsigned ALLRED_CYC = 2,
    parameter int unsigned EMERG_CYC  = 24,
    parameter int unsigned EMERG_LO   = 25,
    parameter int unsigned EMERG_HI   = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cls_valid,
    input  logic [5:0] cls_data,
    input  logic [1:0] cls_lane,
    output logic       cls_ready,
    output logic [7:0] lights,
    output logic [1:0] phase_lane,
    output logic       preempt_active,
    output logic [7:0] drop_cnt
);

    state_t     state, state_nxt;
    logic [1:0] cur_lane, cur_lane_nxt;
    logic [1:0] next_lane, next_lane_nxt;
    logic       pend_valid, pend_valid_nxt;
    logic [1:0] pend_lane, pend_lane_nxt;
    logic       pend_clear;
    logic       emerg_acc;
    logic       tmr_load;
    logic [7:0] tmr_load_val;
    logic       tmr_done;
    logic [7:0] lights_nxt;
    light_t     lane_code;

    // Results are always consumed so that emergencies arriving while one is
    // already pending can be counted as drops.
    assign cls_ready = 1'b1;
    assign emerg_acc = cls_valid && cls_ready && in_range(cls_data, EMERG_LO, EMERG_HI);

    phase_timer #(
        .RST_VAL(8'(ALLRED_CYC - 1))
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .load_val(tmr_load_val),
        .done    (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_ALLRED;
            cur_lane       <= '0;
            next_lane      <= '0;
            pend_valid     <= 1'b0;
            pend_lane      <= '0;
            drop_cnt       <= '0;
            lights         <= '0;
            phase_lane     <= '0;
            preempt_active <= 1'b0;
        end else begin
            state          <= state_nxt;
            cur_lane       <= cur_lane_nxt;
            next_lane      <= next_lane_nxt;
            pend_valid     <= pend_valid_nxt;
            pend_lane      <= pend_lane_nxt;
            lights         <= lights_nxt;
            phase_lane     <= cur_lane_nxt;
            preempt_active <= (state_nxt == ST_EGREEN);
            if (emerg_acc && pend_valid && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        cur_lane_nxt  = cur_lane;
        next_lane_nxt = next_lane;
        pend_clear    = 1'b0;
        tmr_load_val  = '0;
        lane_code     = LIGHT_RED;
        lights_nxt    = '0;

        // Decisions use the registered request; a same-cycle capture waits.
        case (state)
            ST_GREEN: begin
                if (pend_valid && pend_lane == cur_lane) begin
                    state_nxt  = ST_EGREEN;
                    pend_clear = 1'b1;
                end else if (pend_valid || tmr_done) begin
                    state_nxt = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (tmr_done) begin
                    state_nxt     = ST_ALLRED;
                    next_lane_nxt = pend_valid ? pend_lane : cur_lane + 2'd1;
                end
            end
            ST_ALLRED: begin
                if (tmr_done) begin
                    cur_lane_nxt = next_lane;
                    if (pend_valid && pend_lane == next_lane) begin
                        state_nxt  = ST_EGREEN;
                        pend_clear = 1'b1;
                    end else begin
                        state_nxt = ST_GREEN;
                    end
                end
            end
            ST_EGREEN: begin
                if (tmr_done) begin
                    state_nxt = ST_YELLOW;
                end
            end
            default: state_nxt = ST_ALLRED;
        endcase

        tmr_load = (state_nxt != state);
        case (state_nxt)
            ST_GREEN:  tmr_load_val = 8'(GREEN_CYC - 1);
            ST_YELLOW: tmr_load_val = 8'(YELLOW_CYC - 1);
            ST_ALLRED: tmr_load_val = 8'(ALLRED_CYC - 1);
            ST_EGREEN: tmr_load_val = 8'(EMERG_CYC - 1);
            default:   tmr_load_val = '0;
        endcase

        pend_valid_nxt = pend_valid;
        pend_lane_nxt  = pend_lane;
        if (pend_clear) begin
            pend_valid_nxt = 1'b0;
        end
        if (emerg_acc && !pend_valid) begin
            pend_valid_nxt = 1'b1;
            pend_lane_nxt  = cls_lane;
        end

        case (state_nxt)
            ST_GREEN, ST_EGREEN: lane_code = LIGHT_GREEN;
            ST_YELLOW:           lane_code = LIGHT_YELLOW;
            default:             lane_code = LIGHT_RED;
        endcase
        for (int unsigned n = 0; n < NUM_LANES; n++) begin
            lights_nxt[2*n +: 2] = (n == 32'(cur_lane_nxt)) ? lane_code : LIGHT_RED;
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomized and directed bench for traffic_phase_ctrl against a cycle-level
// reference model based on absolute phase end times.
module tb_traffic_phase_ctrl;

    localparam int G_CYC = 16;
    localparam int Y_CYC = 4;
    localparam int A_CYC = 2;
    localparam int E_CYC = 24;
    localparam int E_LO  = 25;
    localparam int E_HI  = 26;

    localparam int K_GO  = 0;
    localparam int K_YEL = 1;
    localparam int K_AR  = 2;
    localparam int K_EG  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cls_valid = 1'b0;
    logic [5:0] cls_data = '0;
    logic [1:0] cls_lane = '0;
    logic       cls_ready;
    logic [7:0] lights;
    logic [1:0] phase_lane;
    logic       preempt_active;
    logic [7:0] drop_cnt;

    always #5 clk = ~clk;

    traffic_phase_ctrl #(
        .GREEN_CYC (G_CYC),
        .YELLOW_CYC(Y_CYC),
        .ALLRED_CYC(A_CYC),
        .EMERG_CYC (E_CYC),
        .EMERG_LO  (E_LO),
        .EMERG_HI  (E_HI)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cls_valid     (cls_valid),
        .cls_data      (cls_data),
        .cls_lane      (cls_lane),
        .cls_ready     (cls_ready),
        .lights        (lights),
        .phase_lane    (phase_lane),
        .preempt_active(preempt_active),
        .drop_cnt      (drop_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: which light phase is shown, on which lane, and the
    // clock count at which the phase ends.
    int m_kind, m_lane, m_next, m_cyc, m_end, m_plane, m_drops;
    bit m_pend;

    function automatic int dur(input int k);
        case (k)
            K_GO:    return G_CYC;
            K_YEL:   return Y_CYC;
            K_AR:    return A_CYC;
            default: return E_CYC;
        endcase
    endfunction

    function automatic void enter(input int k);
        m_kind = k;
        m_end  = m_cyc + dur(k);
    endfunction

    function automatic void model_reset();
        m_kind  = K_AR;
        m_lane  = 0;
        m_next  = 0;
        m_cyc   = 0;
        m_end   = A_CYC;
        m_pend  = 0;
        m_plane = 0;
        m_drops = 0;
    endfunction

    function automatic void model_edge(input bit v, input int d, input int l);
        bit old_pend;
        bit expire;
        old_pend = m_pend;
        m_cyc++;
        expire = (m_cyc == m_end);
        case (m_kind)
            K_GO: begin
                if (old_pend && m_plane == m_lane) begin
                    enter(K_EG);
                    m_pend = 0;
                end else if (old_pend || expire) begin
                    enter(K_YEL);
                end
            end
            K_YEL: begin
                if (expire) begin
                    m_next = old_pend ? m_plane : (m_lane + 1) % 4;
                    enter(K_AR);
                end
            end
            K_AR: begin
                if (expire) begin
                    m_lane = m_next;
                    if (old_pend && m_plane == m_next) begin
                        enter(K_EG);
                        m_pend = 0;
                    end else begin
                        enter(K_GO);
                    end
                end
            end
            default: begin
                if (expire) enter(K_YEL);
            end
        endcase
        if (v && d >= E_LO && d <= E_HI) begin
            if (old_pend) begin
                if (m_drops < 255) m_drops++;
            end else begin
                m_pend  = 1;
                m_plane = l;
            end
        end
    endfunction

    function automatic logic [7:0] exp_lights();
        logic [7:0] r;
        int code;
        r = '0;
        code = (m_kind == K_GO || m_kind == K_EG) ? 2 : (m_kind == K_YEL) ? 1 : 0;
        for (int n = 0; n < 4; n++) begin
            if (n == m_lane) r[2*n +: 2] = 2'(code);
        end
        return r;
    endfunction

    task automatic step(input bit v, input int d, input int l);
        cls_valid = v;
        cls_data  = 6'(d);
        cls_lane  = 2'(l);
        @(posedge clk);
        model_edge(v, d, l);
        @(negedge clk);
        check_val("lights", 32'(lights), 32'(exp_lights()));
        check_val("phase_lane", 32'(phase_lane), 32'(m_lane));
        check_val("preempt", 32'(preempt_active), 32'(m_kind == K_EG));
        check_val("drop_cnt", 32'(drop_cnt), 32'(m_drops));
        check_val("cls_ready", 32'(cls_ready), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cls_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_lights", 32'(lights), 32'h0);
        check_val("rst_preempt", 32'(preempt_active), 32'h0);
        check_val("rst_phase_lane", 32'(phase_lane), 32'h0);
        check_val("rst_drop", 32'(drop_cnt), 32'h0);
        check_val("rst_ready", 32'(cls_ready), 32'h1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cls;
        int r;
        bit v;

        model_reset();
        repeat (2) @(negedge clk);
        check_val("rst_lights", 32'(lights), 32'h0);
        check_val("rst_phase_lane", 32'(phase_lane), 32'h0);
        check_val("rst_preempt", 32'(preempt_active), 32'h0);
        check_val("rst_drop", 32'(drop_cnt), 32'h0);
        check_val("rst_ready", 32'(cls_ready), 32'h1);
        rst_n = 1'b1;

        // Free rotation: lane k turns green after 2 + 22k edges.
        idle(1);
        check_val("rot_red", 32'(lights), 32'h00);
        idle(1);
        check_val("rot_g0", 32'(lights), 32'h02);
        idle(16);
        check_val("rot_y0", 32'(lights), 32'h01);
        idle(4);
        check_val("rot_ar0", 32'(lights), 32'h00);
        idle(2);
        check_val("rot_g1", 32'(lights), 32'h08);
        idle(66);
        check_val("rot_wrap", 32'(lights), 32'h02);

        // Early cut from lane0 green to emergency on lane2, then reset mid-EGREEN.
        do_reset();
        idle(6);
        step(1, 25, 2);
        idle(1);
        check_val("cut_yellow", 32'(lights), 32'h01);
        idle(6);
        check_val("cut_egreen", 32'(lights), 32'h20);
        check_val("cut_preempt", 32'(preempt_active), 32'h1);
        idle(5);
        do_reset();
        idle(2);
        check_val("rst_restart", 32'(lights), 32'h02);

        // Early cut followed by resumed rotation on lane3.
        do_reset();
        idle(6);
        step(1, 25, 2);
        idle(40);
        check_val("cut_resume", 32'(lights), 32'h80);

        // Same-lane extension, drops while pending, and saturation.
        do_reset();
        idle(27);
        step(1, 26, 1);
        idle(1);
        check_val("ext_egreen", 32'(lights), 32'h08);
        check_val("ext_preempt", 32'(preempt_active), 32'h1);
        step(1, 25, 2);
        for (int i = 0; i < 3; i++) step(1, 25, 3);
        check_val("drop3", 32'(drop_cnt), 32'd3);
        idle(30);
        check_val("drop_keep_lane", 32'(lights), 32'h20);
        for (int i = 0; i < 320; i++) step(1, 25, int'($urandom_range(0, 3)));
        check_val("drop_sat", 32'(drop_cnt), 32'd255);

        // Ignored classes do not disturb the rotation.
        do_reset();
        idle(2);
        check_val("ign_g0", 32'(lights), 32'h02);
        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 2));
            cls = (r == 0) ? 0 : (r == 1) ? 12 : 63;
            step(1, cls, int'($urandom_range(0, 3)));
        end
        check_val("ign_drop", 32'(drop_cnt), 32'd0);

        // Randomized traffic with occasional resets.
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            for (int i = 0; i < 1000; i++) begin
                v = ($urandom_range(0, 9) < 3);
                r = int'($urandom_range(0, 19));
                if (r == 0)      cls = int'($urandom_range(25, 26));
                else if (r == 1) cls = 0;
                else if (r <= 3) cls = int'($urandom_range(27, 63));
                else             cls = int'($urandom_range(1, 24));
                step(v, cls, int'($urandom_range(0, 3)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
